// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map, FSM encoding and bus request helpers for the PIO poll master
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT    = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_RD_EDGE = 3'd2;
    localparam state_t ST_WAIT_E  = 3'd3;
    localparam state_t ST_CLR     = 3'd4;
    localparam state_t ST_RD_LVL  = 3'd5;
    localparam state_t ST_WAIT_L  = 3'd6;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } avm_req_t;

    localparam avm_req_t AVM_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 2'd0, wdata: 32'd0};

    function automatic avm_req_t avm_read(input logic [1:0] addr);
        avm_req_t r;
        r      = AVM_IDLE;
        r.cs   = 1'b1;
        r.addr = addr;
        return r;
    endfunction

    function automatic avm_req_t avm_write(input logic [1:0] addr, input logic [31:0] data);
        avm_req_t r;
        r         = AVM_IDLE;
        r.cs      = 1'b1;
        r.write_n = 1'b0;
        r.addr    = addr;
        r.wdata   = data;
        return r;
    endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// rtl/pio_poll_timer.sv - IDLE poll interval counter with clear, enable and terminal count
module pio_poll_timer #(
    parameter int unsigned POLL_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// rtl/pio_poll_master.sv - Avalon-MM initiator polling a single-bit PIO for edges and level
module pio_poll_master
    import pio_pkg::*;
#(
    parameter int unsigned POLL_CYCLES   = 50000,
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic        IRQ_MASK_INIT = 1'b0,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [1:0]         avm_address,
    output logic               avm_chipselect,
    output logic               avm_write_n,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    input  logic               slave_irq,
    output logic               event_pulse,
    output logic [COUNT_W-1:0] event_count,
    output logic               level,
    output logic               busy
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

    state_t             state_q, state_d;
    avm_req_t           req_q, req_d;
    logic [1:0]         lat_q, lat_d;
    logic               pulse_q, pulse_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               level_q, level_d;
    logic               busy_q;
    logic               timer_tc;
    logic               bus_free;
    logic               sample;
    logic               unused_rd;

    assign unused_rd = ^avm_readdata[31:1];

    // A request is only issued after the bus has shown one idle cycle.
    assign bus_free = ~req_q.cs;
    assign sample   = (lat_q == LAT_LAST);

    pio_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (state_q != ST_IDLE),
        .en_i   (enable && (state_q == ST_IDLE)),
        .tc_o   (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = AVM_IDLE;
        lat_d   = 2'd0;
        pulse_d = 1'b0;
        count_d = count_q;
        level_d = level_q;
        case (state_q)
            ST_INIT: begin
                if (bus_free) begin
                    req_d   = avm_write(PIO_ADDR_IRQMASK, {31'd0, IRQ_MASK_INIT});
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (enable && (timer_tc || slave_irq)) begin
                    state_d = ST_RD_EDGE;
                end
            end
            ST_RD_EDGE: begin
                if (bus_free) begin
                    req_d   = avm_read(PIO_ADDR_EDGE);
                    state_d = ST_WAIT_E;
                end
            end
            ST_WAIT_E: begin
                if (sample) begin
                    state_d = avm_readdata[0] ? ST_CLR : ST_RD_LVL;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_CLR: begin
                if (bus_free) begin
                    req_d   = avm_write(PIO_ADDR_EDGE, 32'd0);
                    pulse_d = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                    state_d = ST_RD_LVL;
                end
            end
            ST_RD_LVL: begin
                if (bus_free) begin
                    req_d   = avm_read(PIO_ADDR_DATA);
                    state_d = ST_WAIT_L;
                end
            end
            ST_WAIT_L: begin
                if (sample) begin
                    level_d = avm_readdata[0];
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs trail the FSM by one cycle, so busy is registered from the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            req_q   <= AVM_IDLE;
            lat_q   <= 2'd0;
            pulse_q <= 1'b0;
            count_q <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lat_q   <= lat_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            level_q <= level_d;
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    assign avm_address    = req_q.addr;
    assign avm_chipselect = req_q.cs;
    assign avm_write_n    = req_q.write_n;
    assign avm_writedata  = req_q.wdata;
    assign event_pulse    = pulse_q;
    assign event_count    = count_q;
    assign level          = level_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// tb/tb_pio_poll_master.sv - scoreboard bench for pio_poll_master against a PIO slave model
module tb_pio_poll_master;

    localparam int unsigned POLL = 8;
    localparam int unsigned CW   = 2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          slave_irq;
    logic          event_pulse;
    logic [CW-1:0] event_count;
    logic          level;
    logic          busy;

    logic          button = 1'b0;
    logic          btn_q = 1'b0;
    logic          edge_cap = 1'b0;
    logic          mask = 1'b0;
    logic          irq_force = 1'b0;
    logic [31:0]   rd_data = 32'd0;

    txn_t          exp_q[$];
    logic [CW-1:0] cnt_exp_q[$];
    int            stamp_q[$];
    logic [CW-1:0] exp_count = '0;
    txn_t          mon_got;
    txn_t          mon_exp;
    logic [CW-1:0] mon_cnt;
    int            checks = 0;
    int            errors = 0;
    int            seen = 0;
    int            cyc = 0;

    pio_poll_master #(
        .POLL_CYCLES  (POLL),
        .READ_LATENCY (1),
        .IRQ_MASK_INIT(1'b1),
        .COUNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .slave_irq     (slave_irq),
        .event_pulse   (event_pulse),
        .event_count   (event_count),
        .level         (level),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    assign avm_readdata = rd_data;
    assign slave_irq    = (edge_cap & mask) | irq_force;

    // Slave model: registered readdata, rising-edge capture, clear has priority.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        btn_q <= button;
        rd_data <= 32'd0;
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                2'd0:    rd_data <= {31'h2D5A_A5C3, button};
                2'd2:    rd_data <= {31'h0000_0000, mask};
                2'd3:    rd_data <= {31'h7FFF_FFFF, edge_cap};
                default: rd_data <= 32'd0;
            endcase
        end
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
            edge_cap <= 1'b0;
        end else if (button && !btn_q) begin
            edge_cap <= 1'b1;
        end
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2) begin
            mask <= avm_writedata[0];
        end
    end

    always @(negedge clk) begin
        if (reset_n && avm_chipselect) begin
            mon_got = '{wr: ~avm_write_n, addr: avm_address, data: avm_writedata};
            seen   = seen + 1;
            checks = checks + 1;
            if (!mon_got.wr && mon_got.addr == 2'd3) stamp_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%0h, required no transaction",
                         mon_got.wr, mon_got.addr, mon_got.data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL bus_txn: got wr=%0b addr=%0d data=%0h, required wr=%0b addr=%0d data=%0h",
                             mon_got.wr, mon_got.addr, mon_got.data, mon_exp.wr, mon_exp.addr, mon_exp.data);
                end
            end
        end
        if (reset_n && event_pulse) begin
            checks = checks + 1;
            if (cnt_exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pulse_unexpected: got event_count=%0d, required no pulse", event_count);
            end else begin
                mon_cnt = cnt_exp_q.pop_front();
                if (event_count !== mon_cnt) begin
                    errors = errors + 1;
                    $display("FAIL event_count: got %0d, required %0d", event_count, mon_cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_txn(input logic wr, input logic [1:0] a, input logic [31:0] d);
        exp_q.push_back('{wr: wr, addr: a, data: d});
    endtask

    task automatic push_poll(input logic with_edge);
        push_txn(1'b0, 2'd3, 32'd0);
        if (with_edge) begin
            push_txn(1'b1, 2'd3, 32'd0);
            exp_count = exp_count + 2'd1;
            cnt_exp_q.push_back(exp_count);
        end
        push_txn(1'b0, 2'd0, 32'd0);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s: %0d bus cycles still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_intervals(input string name, input int step);
        chk({name, "_polls"}, 32'(stamp_q.size()), 32'd3);
        if (stamp_q.size() == 3) begin
            chk({name, "_gap1"}, 32'(stamp_q[1] - stamp_q[0]), 32'(step));
            chk({name, "_gap2"}, 32'(stamp_q[2] - stamp_q[1]), 32'(step));
        end
    endtask

    initial begin
        int s0;
        int n;
        logic rel;

        tick(3);
        chk("rst_cs",      32'(avm_chipselect), 32'd0);
        chk("rst_write_n", 32'(avm_write_n),    32'd1);
        chk("rst_addr",    32'(avm_address),    32'd0);
        chk("rst_wdata",   avm_writedata,       32'd0);
        chk("rst_pulse",   32'(event_pulse),    32'd0);
        chk("rst_count",   32'(event_count),    32'd0);
        chk("rst_level",   32'(level),          32'd0);
        chk("rst_busy",    32'(busy),           32'd1);

        push_txn(1'b1, 2'd2, 32'd1);
        reset_n = 1'b1;
        tick(1);
        chk("init_write_cs", 32'(avm_chipselect), 32'd1);
        chk("init_busy_hi",  32'(busy), 32'd1);
        tick(1);
        chk("init_busy_fall", 32'(busy), 32'd0);
        chk("init_bus_idle",  32'(avm_chipselect), 32'd0);
        wait_empty("init");

        // Timer-driven polls, no edges: 8 IDLE cycles + 6 cycles of transaction per poll.
        stamp_q.delete();
        repeat (3) push_poll(1'b0);
        enable = 1'b1;
        wait_empty("timer_polls");
        enable = 1'b0;
        tick(4);
        check_intervals("timer", 14);
        chk("timer_count", 32'(event_count), 32'd0);
        chk("timer_level", 32'(level), 32'd0);

        button = 1'b1;
        push_poll(1'b1);
        enable = 1'b1;
        wait_empty("single_press");
        enable = 1'b0;
        tick(4);
        chk("press_level", 32'(level), 32'd1);
        chk("press_count", 32'(event_count), 32'd1);

        // Four more edges: count goes 2,3,0,1; alternate presses are released before the level read.
        for (int k = 0; k < 4; k++) begin
            button = 1'b0;
            tick(2);
            button = 1'b1;
            tick(2);
            rel = (k % 2 == 0);
            if (rel) button = 1'b0;
            tick(2);
            push_poll(1'b1);
            enable = 1'b1;
            wait_empty("multi_press");
            enable = 1'b0;
            tick(4);
            chk("multi_level", 32'(level), rel ? 32'd0 : 32'd1);
            chk("multi_count", 32'(event_count), 32'(exp_count));
        end

        stamp_q.delete();
        repeat (3) push_poll(1'b0);
        irq_force = 1'b1;
        enable    = 1'b1;
        wait_empty("irq_held");
        enable    = 1'b0;
        irq_force = 1'b0;
        tick(4);
        check_intervals("irq", 7);

        push_poll(1'b0);
        irq_force = 1'b1;
        enable    = 1'b1;
        tick(1);
        enable    = 1'b0;
        irq_force = 1'b0;
        tick(20);
        chk("en_drop_pending", 32'(exp_q.size()), 32'd0);
        chk("en_drop_busy", 32'(busy), 32'd0);

        push_txn(1'b0, 2'd3, 32'd0);
        s0 = seen;
        irq_force = 1'b1;
        enable    = 1'b1;
        n = 0;
        while (seen == s0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("rst_mid_reached", 32'(seen - s0), 32'd1);
        reset_n   = 1'b0;
        enable    = 1'b0;
        irq_force = 1'b0;
        #1;
        chk("rst_mid_cs",      32'(avm_chipselect), 32'd0);
        chk("rst_mid_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_mid_busy",    32'(busy), 32'd1);
        chk("rst_mid_count",   32'(event_count), 32'd0);
        chk("rst_mid_level",   32'(level), 32'd0);
        push_txn(1'b1, 2'd2, 32'd1);
        tick(2);
        reset_n = 1'b1;
        wait_empty("reinit");
        tick(3);
        chk("reinit_busy", 32'(busy), 32'd0);
        chk("pulses_pending", 32'(cnt_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
